// File: rtl/order_tx.sv
// order_tx: order transmitter for the egress end of the strategy path.
// It captures single-cycle order strobes into a small FIFO and sends each
// order to the host/exchange side as a multi-beat Avalon-ST packet.
// The strategy side cannot be stalled. When the FIFO is full, an order is
// dropped and counted.
//
// Optional feature macro: ORDER_TX_TSTAMP_EN
//   When defined, a free-running 64-bit cycle timestamp is captured at push.
//   It is sent as a third beat, and endofpacket moves to that beat.
//
// Parameters:
//   FIFO_DEPTH : order entries buffered (power of two, >= 2)
//   MSG_ORDER  : message type code placed in beat 0 [63:40]
//
// Ports:
//   clk, reset        : core clock, synchronous active-high reset
//   ord_valid         : one-cycle order strobe
//   ord_sym           : translated symbol ID
//   ord_side          : 0 = buy, 1 = sell
//   ord_price/ord_vol : order price / volume
//   tx_valid, tx_ready, tx_data, tx_startofpacket, tx_endofpacket :
//                       tx_if Avalon-ST source (ready latency 0), all registered
//   ovf_cnt           : saturating count of dropped orders
//   ovf_flag          : sticky, set on the first drop

package order_tx_pkg;

    // One buffered order
    typedef struct packed {
`ifdef ORDER_TX_TSTAMP_EN
        logic [63:0] tstamp;
`endif
        logic [15:0] seq;
        logic        side;
        logic [15:0] sym;
        logic [31:0] price;
        logic [31:0] vol;
    } order_entry_t;

endpackage

module order_tx
    import order_tx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [23:0] MSG_ORDER  = 24'h4F5244
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ord_valid,
    input  logic [15:0] ord_sym,
    input  logic        ord_side,
    input  logic [31:0] ord_price,
    input  logic [31:0] ord_vol,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [63:0] tx_data,
    output logic        tx_startofpacket,
    output logic        tx_endofpacket,
    output logic [15:0] ovf_cnt,
    output logic        ovf_flag
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BEAT0,
        S_BEAT1
`ifdef ORDER_TX_TSTAMP_EN
        , S_BEAT2
`endif
    } state_t;

    state_t state_q, state_d;

    order_entry_t mem [FIFO_DEPTH];
    order_entry_t in_ent;

    logic [PW-1:0] wr_ptr, rd_ptr, rd_next;
    logic [AW-1:0] rd_idx, rd_next_idx;
    logic [15:0]   seq_q;

    logic full_c, empty_c;
    logic fire_c, last_c, pop_c, push_c, drop_c;
    logic nxt_nonempty_c, head_avail_c;

    logic [15:0] nh_sym, nh_seq;
    logic        nh_side;

    logic        valid_d, sop_d, eop_d;
    logic [63:0] data_d;

`ifdef ORDER_TX_TSTAMP_EN
    logic [63:0] cyc_cnt;

    // Free-running cycle counter for order timestamps
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_cnt <= 64'd0;
        end else begin
            cyc_cnt <= cyc_cnt + 64'd1;
        end
    end
`endif

    // Full and empty are told apart by the extra pointer MSB
    assign rd_idx  = rd_ptr[AW-1:0];
    assign empty_c = (wr_ptr == rd_ptr);
    assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A handshake pops the head only on the packet's last beat
    assign fire_c = tx_valid & tx_ready;
`ifdef ORDER_TX_TSTAMP_EN
    assign last_c = (state_q == S_BEAT2);
`else
    assign last_c = (state_q == S_BEAT1);
`endif
    assign pop_c  = fire_c & last_c;
    assign push_c = ord_valid & (~full_c | pop_c);
    assign drop_c = ord_valid & full_c & ~pop_c;

    // Entry assembled from the incoming strobe
    always_comb begin
        in_ent        = '0;
`ifdef ORDER_TX_TSTAMP_EN
        in_ent.tstamp = cyc_cnt;
`endif
        in_ent.seq    = seq_q;
        in_ent.side   = ord_side;
        in_ent.sym    = ord_sym;
        in_ent.price  = ord_price;
        in_ent.vol    = ord_vol;
    end

    // Head for the next packet after this cycle's pop. If the FIFO would be empty,
    // the same-cycle push is forwarded so beat 0 can appear one cycle after push.
    assign rd_next        = rd_ptr + PW'(pop_c);
    assign rd_next_idx    = rd_next[AW-1:0];
    assign nxt_nonempty_c = (wr_ptr != rd_next);
    assign head_avail_c   = nxt_nonempty_c | push_c;

    always_comb begin
        nh_sym  = ord_sym;
        nh_seq  = seq_q;
        nh_side = ord_side;
        if (nxt_nonempty_c) begin
            nh_sym  = mem[rd_next_idx].sym;
            nh_seq  = mem[rd_next_idx].seq;
            nh_side = mem[rd_next_idx].side;
        end
    end

    // Next-state and next-output logic; outputs hold unless a beat is accepted
    always_comb begin
        state_d = state_q;
        valid_d = tx_valid;
        data_d  = tx_data;
        sop_d   = tx_startofpacket;
        eop_d   = tx_endofpacket;

        unique case (state_q)
            S_IDLE: begin
                if (head_avail_c) begin
                    state_d = S_BEAT0;
                    valid_d = 1'b1;
                    data_d  = {MSG_ORDER, nh_sym, nh_seq, 7'd0, nh_side};
                    sop_d   = 1'b1;
                    eop_d   = 1'b0;
                end
            end
            S_BEAT0: begin
                if (fire_c) begin
                    state_d = S_BEAT1;
                    data_d  = {mem[rd_idx].price, mem[rd_idx].vol};
                    sop_d   = 1'b0;
`ifdef ORDER_TX_TSTAMP_EN
                    eop_d   = 1'b0;
`else
                    eop_d   = 1'b1;
`endif
                end
            end
`ifdef ORDER_TX_TSTAMP_EN
            S_BEAT1: begin
                if (fire_c) begin
                    state_d = S_BEAT2;
                    data_d  = mem[rd_idx].tstamp;
                    eop_d   = 1'b1;
                end
            end
            S_BEAT2: begin
`else
            S_BEAT1: begin
`endif
                if (fire_c) begin
                    if (head_avail_c) begin
                        state_d = S_BEAT0;
                        valid_d = 1'b1;
                        data_d  = {MSG_ORDER, nh_sym, nh_seq, 7'd0, nh_side};
                        sop_d   = 1'b1;
                        eop_d   = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        valid_d = 1'b0;
                        data_d  = 64'd0;
                        sop_d   = 1'b0;
                        eop_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                data_d  = 64'd0;
                sop_d   = 1'b0;
                eop_d   = 1'b0;
            end
        endcase
    end

    // State and registered Avalon-ST outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            tx_valid         <= 1'b0;
            tx_data          <= 64'd0;
            tx_startofpacket <= 1'b0;
            tx_endofpacket   <= 1'b0;
        end else begin
            state_q          <= state_d;
            tx_valid         <= valid_d;
            tx_data          <= data_d;
            tx_startofpacket <= sop_d;
            tx_endofpacket   <= eop_d;
        end
    end

    // FIFO pointers, sequence number and overflow accounting
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            seq_q    <= 16'd0;
            ovf_cnt  <= 16'd0;
            ovf_flag <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PW'(1);
                seq_q  <= seq_q + 16'd1;
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (drop_c) begin
                ovf_flag <= 1'b1;
                if (ovf_cnt != 16'hFFFF) begin
                    ovf_cnt <= ovf_cnt + 16'd1;
                end
            end
        end
    end

    // FIFO storage has no reset; the pointers define what is valid
    always_ff @(posedge clk) begin
        if (!reset && push_c) begin
            mem[wr_ptr[AW-1:0]] <= in_ent;
        end
    end

    logic unused_ok;
    assign unused_ok = empty_c;

endmodule

// File: tb/tb_order_tx.sv
module tb_order_tx;

    localparam int DEPTH = 4;
`ifdef ORDER_TX_TSTAMP_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ord_valid = 1'b0;
    logic [15:0] ord_sym = 16'd0;
    logic        ord_side = 1'b0;
    logic [31:0] ord_price = 32'd0;
    logic [31:0] ord_vol = 32'd0;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [63:0] tx_data;
    logic        tx_startofpacket;
    logic        tx_endofpacket;
    logic [15:0] ovf_cnt;
    logic        ovf_flag;

    order_tx #(.FIFO_DEPTH(DEPTH), .MSG_ORDER(24'h4F5244)) dut (
        .clk              (clk),
        .reset            (reset),
        .ord_valid        (ord_valid),
        .ord_sym          (ord_sym),
        .ord_side         (ord_side),
        .ord_price        (ord_price),
        .ord_vol          (ord_vol),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .tx_data          (tx_data),
        .tx_startofpacket (tx_startofpacket),
        .tx_endofpacket   (tx_endofpacket),
        .ovf_cnt          (ovf_cnt),
        .ovf_flag         (ovf_flag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of orders awaiting transmission, head being sent
    typedef struct {
        logic [15:0] seq;
        logic [15:0] sym;
        logic        side;
        logic [31:0] price;
        logic [31:0] vol;
        logic [63:0] ts;
    } ord_t;

    ord_t        mq[$];
    int          mb = 0;
    bit          mact = 1'b0;
    logic [15:0] mseq = 16'd0;
    logic [15:0] mcnt = 16'd0;
    bit          mflag = 1'b0;
    logic [63:0] mcyc = 64'd0;
    bit          started = 1'b0;

    function automatic logic [63:0] beat_data(input ord_t o, input int b);
        if (b == 0) return {24'h4F5244, o.sym, o.seq, 7'd0, o.side};
        if (b == 1) return {o.price, o.vol};
        return o.ts;
    endfunction

    always @(posedge clk) begin : model
        bit   fire;
        bit   last;
        int   sz;
        ord_t o;
        if (reset) begin
            mq.delete();
            mb      = 0;
            mact    = 1'b0;
            mseq    = 16'd0;
            mcnt    = 16'd0;
            mflag   = 1'b0;
            mcyc    = 64'd0;
            started = 1'b1;
        end else begin
            fire = mact && tx_ready;
            last = fire && (mb == NB - 1);
            sz   = mq.size();
            if (ord_valid) begin
                if (sz < DEPTH || last) begin
                    o.seq   = mseq;
                    o.sym   = ord_sym;
                    o.side  = ord_side;
                    o.price = ord_price;
                    o.vol   = ord_vol;
                    o.ts    = mcyc;
                    mq.push_back(o);
                    mseq = mseq + 16'd1;
                end else begin
                    if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
                    mflag = 1'b1;
                end
            end
            if (last) begin
                void'(mq.pop_front());
                mb = 0;
            end else if (fire) begin
                mb = mb + 1;
            end
            mact = (mq.size() != 0);
            mcyc = mcyc + 64'd1;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (started) begin
            check("valid", 64'(tx_valid), 64'(mact));
            check("data", tx_data, mact ? beat_data(mq[0], mb) : 64'd0);
            check("sop", 64'(tx_startofpacket), 64'(mact && mb == 0));
            check("eop", 64'(tx_endofpacket), 64'(mact && mb == NB - 1));
            check("ovf_cnt", 64'(ovf_cnt), 64'(mcnt));
            check("ovf_flag", 64'(ovf_flag), 64'(mflag));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] sym, input logic side,
                        input logic [31:0] price, input logic [31:0] vol);
        ord_valid = 1'b1;
        ord_sym   = sym;
        ord_side  = side;
        ord_price = price;
        ord_vol   = vol;
        tick();
        ord_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        check("rst_valid", 64'(tx_valid), 64'd0);
        check("rst_data", tx_data, 64'd0);
        check("rst_ovf_cnt", 64'(ovf_cnt), 64'd0);
        check("rst_ovf_flag", 64'(ovf_flag), 64'd0);
        reset = 1'b0;
        tx_ready = 1'b1;
        repeat (5) tick();

        // Single order with ready high
        send(16'h0012, 1'b1, 32'd1000, 32'd50);
        check("t1_beat0", tx_data, 64'h4F5244_0012_0000_01);
        check("t1_sop", 64'(tx_startofpacket), 64'd1);
        tick();
        check("t1_beat1", tx_data, 64'h000003E8_00000032);
        check("t1_eop", 64'(tx_endofpacket), 64'd1);
        tick();
        check("t1_idle", 64'(tx_valid), 64'd0);

        // Backpressure on beat 0
        tx_ready = 1'b0;
        send(16'h1234, 1'b0, 32'd7, 32'd9);
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", 64'(tx_valid), 64'd1);
            check("t2_hold_data", tx_data, 64'h4F5244_1234_0001_00);
            tick();
        end
        tx_ready = 1'b1;
        tick();
        check("t2_beat1", tx_data, 64'h00000007_00000009);
        tick();
        check("t2_idle", 64'(tx_valid), 64'd0);

        // Overflow: six orders into a depth-4 FIFO with ready low
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tx_ready = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            send(16'(16'h0100 + i), 1'(i % 2), 32'(i * 10), 32'(i));
        end
        check("t3_ovf_cnt", 64'(ovf_cnt), 64'd2);
        check("t3_ovf_flag", 64'(ovf_flag), 64'd1);
        check("t3_head", tx_data, 64'h4F5244_0100_0000_00);
        tx_ready = 1'b1;
        repeat (10) tick();
        check("t3_drained", 64'(tx_valid), 64'd0);
        send(16'h00AA, 1'b0, 32'd1, 32'd2);
        check("t3_seq4", tx_data, 64'h4F5244_00AA_0004_00);
        repeat (3) tick();

        // Full FIFO with a push in the same cycle as the last-beat pop
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(16'(16'h0200 + i), 1'b1, 32'(100 + i), 32'(i));
        end
        tx_ready = 1'b1;
        tick();
        send(16'h0C0C, 1'b0, 32'd55, 32'd66);
        check("t4_ovf_cnt", 64'(ovf_cnt), 64'd2);
        check("t4_next_head", tx_data, 64'h4F5244_0201_0006_01);
        repeat (12) tick();
        check("t4_drained", 64'(tx_valid), 64'd0);

        // Reset during beat 1 with two orders queued
        tx_ready = 1'b0;
        send(16'h0301, 1'b0, 32'd1, 32'd1);
        send(16'h0302, 1'b1, 32'd2, 32'd2);
        tx_ready = 1'b1;
        tick();
        check("t5_in_beat1", 64'(tx_endofpacket), 64'd1);
        reset = 1'b1;
        tick();
        check("t5_valid", 64'(tx_valid), 64'd0);
        check("t5_eop", 64'(tx_endofpacket), 64'd0);
        check("t5_ovf_cnt", 64'(ovf_cnt), 64'd0);
        reset = 1'b0;
        tick();
        send(16'h0BEE, 1'b1, 32'd3, 32'd4);
        check("t5_seq0", tx_data, 64'h4F5244_0BEE_0000_01);
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
